// File: rtl/prog_num_pkg.sv
// rtl/prog_num_pkg.sv - shared state encoding and timing defaults for the program-number serial link
package prog_num_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        GAP   = 3'd4
    } tx_state_t;

    localparam int DEFAULT_BIT_TIME = 256;
    localparam int DEFAULT_GAP_BITS = 2;

endpackage

// File: rtl/prog_num_bit_timer.sv
// rtl/prog_num_bit_timer.sv - bit-period timer, one tick every BIT_TIME cycles after restart
module prog_num_bit_timer
    import prog_num_pkg::*;
#(
    parameter int BIT_TIME = DEFAULT_BIT_TIME
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = $clog2(BIT_TIME);
    localparam logic [CW-1:0] LAST = CW'(BIT_TIME - 1);

    logic [CW-1:0] cnt;

    // Reloading on tick keeps every bit exactly BIT_TIME cycles; cnt never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/prog_num_tx.sv
// rtl/prog_num_tx.sv - serial program-number transmitter: start bit, LSB-first data, stop bit, idle gap
module prog_num_tx
    import prog_num_pkg::*;
#(
    parameter int PROG_NUM_SIZE = 8,
    parameter int BIT_TIME      = DEFAULT_BIT_TIME,
    parameter int GAP_BITS      = DEFAULT_GAP_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PROG_NUM_SIZE-1:0] progNum,
    input  logic                     load,
    output logic                     ready,
    output logic                     serOut
);

    localparam int IW = $clog2(PROG_NUM_SIZE + 1);
    localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [IW-1:0] LAST_BIT = IW'(PROG_NUM_SIZE - 1);
    localparam logic [GW-1:0] LAST_GAP = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    tx_state_t                state, state_next;
    logic [PROG_NUM_SIZE-1:0] shift, shift_next;
    logic [IW-1:0]            idx, idx_next;
    logic [GW-1:0]            gap_cnt, gap_cnt_next;
    logic                     ser_next;
    logic                     restart;
    logic                     tick;

    // Timer is held at zero while idle so the first START cycle begins a full bit.
    prog_num_bit_timer #(
        .BIT_TIME (BIT_TIME)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    assign restart = (state == IDLE);
    assign ready   = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shift   <= '0;
            idx     <= '0;
            gap_cnt <= '0;
            serOut  <= 1'b1;
        end else begin
            state   <= state_next;
            shift   <= shift_next;
            idx     <= idx_next;
            gap_cnt <= gap_cnt_next;
            serOut  <= ser_next;
        end
    end

    always_comb begin
        state_next   = state;
        shift_next   = shift;
        idx_next     = idx;
        gap_cnt_next = gap_cnt;
        ser_next     = serOut;
        case (state)
            IDLE: begin
                ser_next = 1'b1;
                if (load) begin
                    state_next = START;
                    shift_next = progNum;
                    ser_next   = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                    ser_next   = shift[0];
                    shift_next = shift >> 1;
                    idx_next   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx == LAST_BIT) begin
                        state_next = STOP;
                        ser_next   = 1'b1;
                    end else begin
                        idx_next   = idx + 1'b1;
                        ser_next   = shift[0];
                        shift_next = shift >> 1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    gap_cnt_next = '0;
                    state_next   = (GAP_BITS == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    if (gap_cnt == LAST_GAP) begin
                        state_next = IDLE;
                    end else begin
                        gap_cnt_next = gap_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                ser_next   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_prog_num_tx.sv
// tb/tb_prog_num_tx.sv - randomized self-checking bench for prog_num_tx against a frame-shape model
module tb_prog_num_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load1, load2;
    logic [7:0] prog1, prog2;
    logic       ready1, ready2, ser1, ser2;

    int checks = 0;
    int errors = 0;

    prog_num_tx #(.PROG_NUM_SIZE(8), .BIT_TIME(4), .GAP_BITS(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .progNum (prog1),
        .load    (load1),
        .ready   (ready1),
        .serOut  (ser1)
    );

    prog_num_tx #(.PROG_NUM_SIZE(8), .BIT_TIME(2), .GAP_BITS(0)) dut_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .progNum (prog2),
        .load    (load2),
        .ready   (ready2),
        .serOut  (ser2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame model: bit period b of the frame is start(0), data LSB first, then high.
    function automatic logic exp_bit(input logic [7:0] v, input int bt, input int c);
        int b;
        b = c / bt;
        if (b == 0) return 1'b0;
        if (b <= 8) return v[b-1];
        return 1'b1;
    endfunction

    task automatic drive(input bit sel, input logic l, input logic [7:0] v);
        if (sel) begin
            load2 = l;
            prog2 = v;
        end else begin
            load1 = l;
            prog1 = v;
        end
    endtask

    // Sends v, then compares every frame cycle; busy_at pulses a 3C load mid-frame,
    // late_load pulses a 01 load on the cycle whose edge returns the DUT to idle.
    task automatic run_frame(input bit sel, input logic [7:0] v, input int busy_at, input bit late_load);
        int   bt;
        int   len;
        int   low;
        logic s;
        logic r;
        bt  = sel ? 2 : 4;
        len = sel ? 20 : 48;
        low = 0;
        drive(sel, 1'b1, v);
        @(negedge clk);
        for (int c = 0; c < len; c++) begin
            s = sel ? ser2 : ser1;
            r = sel ? ready2 : ready1;
            check($sformatf("ser%0d_v%0h_c%0d", sel, v, c), 32'(s), 32'(exp_bit(v, bt, c)));
            if (!r) low++;
            if (c == busy_at)
                drive(sel, 1'b1, 8'h3C);
            else if (late_load && c == len - 1)
                drive(sel, 1'b1, 8'h01);
            else
                drive(sel, 1'b0, 8'($urandom));
            @(negedge clk);
        end
        check($sformatf("ready_low%0d_v%0h", sel, v), 32'(low), 32'(len));
        r = sel ? ready2 : ready1;
        check($sformatf("ready_back%0d_v%0h", sel, v), 32'(r), 32'd1);
        drive(sel, 1'b0, 8'($urandom));
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            check("idle_ready", 32'(ready1), 32'd1);
            check("idle_ser", 32'(ser1), 32'd1);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        load1 = 1'b0;
        load2 = 1'b0;
        prog1 = 8'h00;
        prog2 = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_ready1", 32'(ready1), 32'd1);
        check("rst_ser1", 32'(ser1), 32'd1);
        check("rst_ready2", 32'(ready2), 32'd1);
        check("rst_ser2", 32'(ser2), 32'd1);

        // First cycle after release must accept the load.
        rst_n = 1'b1;
        run_frame(1'b0, 8'hA5, -1, 1'b0);

        run_frame(1'b0, 8'hA5, 10, 1'b0);
        idle_check(8);

        run_frame(1'b0, 8'($urandom), -1, 1'b1);
        run_frame(1'b0, 8'h80, -1, 1'b0);
        idle_check(2);

        drive(1'b0, 1'b1, 8'hFF);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00);
        repeat (17) @(negedge clk);
        check("midframe_busy", 32'(ready1), 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_rst_ser", 32'(ser1), 32'd1);
        check("async_rst_ready", 32'(ready1), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(1'b0, 8'h55, -1, 1'b0);
        idle_check(2);

        run_frame(1'b1, 8'hC3, -1, 1'b0);
        run_frame(1'b1, 8'($urandom), -1, 1'b1);
        run_frame(1'b1, 8'($urandom), int'($urandom_range(0, 19)), 1'b0);

        for (int k = 0; k < 6; k++) begin
            run_frame(1'b0, 8'($urandom), int'($urandom_range(0, 47)), 1'($urandom_range(0, 1)));
        end
        idle_check(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_num_tx.md
PROG_NUM_TX -- requirements
Module: prog_num_tx

Interface
REQ-001 SHALL have parameter PROG_NUM_SIZE, default 8: program-number width in bits.
REQ-002 SHALL have parameter BIT_TIME, default 256: clock cycles per serial bit; legal range is 2..32768.
REQ-003 SHALL have parameter GAP_BITS, default 2: idle-high bit periods enforced after each stop bit.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset is asynchronous and active-low.
REQ-006 SHALL have port progNum, input, PROG_NUM_SIZE bits: program number to send.
REQ-007 SHALL have port load, input, 1 bit: single-cycle send request.
REQ-008 SHALL have port ready, output, 1 bit: high only in IDLE; load is accepted only when ready is high.
REQ-009 SHALL have port serOut, output, 1 bit: serial line, idle high.

Function
REQ-010 SHALL implement the FSM states IDLE, START, DATA, STOP and GAP.
REQ-011 SHALL, in IDLE with load=1, capture progNum into a shift register and enter START on the next edge.
REQ-012 SHALL drive ready low from that same edge.
REQ-013 SHALL ignore load when ready=0: no queueing, and no corruption of the frame in flight.
REQ-014 SHALL register serOut, so serOut changes on the clock edge that enters each state or bit.
REQ-015 SHALL drive serOut low for exactly BIT_TIME cycles in START.
REQ-016 SHALL, in DATA, send PROG_NUM_SIZE bits LSB first, each for exactly BIT_TIME cycles.
REQ-017 SHALL, in STOP, drive serOut high for BIT_TIME cycles.
REQ-018 SHALL, in GAP, hold serOut high for GAP_BITS*BIT_TIME cycles; GAP_BITS=0 skips GAP.
REQ-019 SHALL make the total frame (PROG_NUM_SIZE+2+GAP_BITS)*BIT_TIME cycles from the first START cycle until ready returns high.
REQ-020 SHALL use a bit-period counter of $clog2(BIT_TIME) bits.
REQ-021 SHALL reload the bit-period counter to 0 at every state or bit transition, and never let it wrap mid-bit.
REQ-022 SHALL use a bit index of $clog2(PROG_NUM_SIZE+1) bits, compared against PROG_NUM_SIZE-1 to leave DATA.
REQ-023 SHALL raise ready on the edge that returns to IDLE.
REQ-024 SHALL NOT accept a load asserted on that same edge; the earliest accepted load is in the following cycle.
REQ-025 SHALL ignore progNum changes during a frame; the transmitted value is the one captured at acceptance.
REQ-026 SHALL permit back-to-back frames; the minimum spacing between START edges is the full frame length.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force state=IDLE, serOut=1, ready=1, and clear the shift register, bit counter and bit index.
REQ-028 SHALL, on reset mid-frame, return serOut high immediately and discard the frame with no partial completion afterwards.
REQ-029 SHALL, after rst_n deasserts, accept a load in the first clock cycle.

Structure
REQ-030 SHALL place the state enum (IDLE/START/DATA/STOP/GAP) and the default BIT_TIME and GAP_BITS constants in shared package prog_num_pkg; the receiver uses the same package.
REQ-031 SHALL implement the bit-period timer as one sub-module, prog_num_bit_timer (clk, rst_n, restart, tick); tick is high for one cycle every BIT_TIME cycles after restart.
REQ-032 SHALL keep the FSM and the shift register in prog_num_tx itself.

Verification (BIT_TIME=4, GAP_BITS=2, PROG_NUM_SIZE=8)
REQ-033 Basic frame: load with progNum=8'hA5 -> serOut = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 12 cycles; ready low for exactly 48 cycles.
REQ-034 Busy load: load with progNum=8'h3C during the DATA state of an 8'hA5 frame -> the frame carries 8'hA5 intact and no second frame follows.
REQ-035 Back-to-back: load 8'h01 as ready rises, then 8'h80 -> the first load is ignored and the second is accepted the next cycle; two consecutive frames, 8'h00-equivalent gap not shortened.
REQ-036 Mid-frame reset: rst_n low during bit 3 of an 8'hFF frame -> serOut=1 and ready=1 asynchronously; a load of 8'h55 right after release -> a clean 8'h55 frame.
REQ-037 Loopback: connect serOut to the team's serial program-number receiver and send 8'h00, 8'hFF, 8'h5A -> the receiver's decoded progNum matches each value after its stability window.
REQ-038 Edge parameters: BIT_TIME=2 and GAP_BITS=0 with 8'hC3 -> 20-cycle frame and correct bit order.
